l1_mshr: RTL and testbench
==========================

// Module: l1_mshr
// PURPOSE
//  Miss Status Holding Register file for the non-blocking L1 data cache.
//  - Each L1 miss allocates one entry.
//  - Entries are issued to L2 in index order (read_next).
//  - Each entry is read back when the L2 fill returns (get) and freed afterwards (del).
//  - A combinational lookup flags same-line / same-set conflicts so the cache controller can block or merge.
// PARAMETERS
//  ADDR_BITS    32  byte-address width
//  DATA_BITS    32  store-data width per entry
//  ID_BITS      3   entry index width; ENTRIES = 2**ID_BITS
//  CPU_ID_BITS  4   core ld/st queue id width
//  ASSOC_BITS   1   victim-way field width
//  LINE_BITS    5   log2(line bytes)
//  INDEX_BITS   9   log2(sets)
//  WORDS        8   words per line; used only with SIMD_WORD_VALID_EN
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            async active-low reset
//  enable       in   1            0 = freeze all state; outputs still reflect current state
//  add, add_addr/data/rw/dirty/cpu_id/victim  in  1/ADDR/DATA/1/1/CPU_ID/ASSOC   allocate request
//  del, del_tag                   in   1/ID      free entry del_tag
//  read_next                      in   1         issue oldest pending entry
//  rn_valid, rn_addr/data/rw/dirty/cpu_id/victim, rn_mshr_id  out  issued entry (registered)
//  get, get_tag                   in   1/ID      fetch entry on L2 return
//  get_valid, get_addr/data/rw/dirty/cpu_id/victim           out  fetched entry (registered)
//  comp_addr, comp_victim         in   ADDR/ASSOC  lookup key
//  comp_true, same_line_true, diff_line_true, comp_read      out  1 each, combinational
//  empty, full                    out  1 each, combinational
// BEHAVIOUR
//  - Reset state: all entries FREE; every registered output is 0; empty=1; full=0.
//  - Per-entry state: FREE -> PEND (add) -> ISSUED (read_next) -> FREE (del).
//    - del is accepted in PEND or ISSUED state.
//  - add: writes the lowest-index FREE entry and sets it to PEND.
//    - Ignored when full=1.
//  - read_next: selects the lowest-index PEND entry and marks it ISSUED.
//    - Next cycle: rn_valid=1, rn_* carry its fields, rn_mshr_id = its index.
//    - No PEND entry: rn_valid=0 next cycle.
//    - rn_valid is 0 in every cycle not following a read_next.
//  - get: if entry get_tag is not FREE, next cycle get_valid=1 with its fields; otherwise get_valid=0.
//    - The entry is not modified by get.
//  - del: entry del_tag becomes FREE. del on a FREE entry is a no-op.
//  - Same-cycle events:
//    - add, del, read_next and get all act on pre-edge state.
//    - add never takes the slot freed in that same cycle.
//    - full/empty are computed from pre-edge state.
//  - Lookup (combinational; only non-FREE entries participate):
//    - line(a) = a[ADDR_BITS-1:LINE_BITS]; set(a) = a[INDEX_BITS+LINE_BITS-1:LINE_BITS].
//    - same_line_true: some entry has line == line(comp_addr).
//    - diff_line_true: some entry has the same set, a different line, and victim == comp_victim.
//    - comp_true = same_line_true | diff_line_true.
//    - comp_read: ~rw of the lowest-index matching entry; same-line matches take priority; 0 when there is no match.
//  - empty = no entry in use; full = every entry in use.
//  - enable=0: add, del, read_next and get are all ignored; rn_valid and get_valid drive 0 next cycle.
//  - Reset asserted mid-operation: all entries are freed immediately; in-flight rn/get results are discarded.
// CONFIGURATION
//  - Macro SIMD_WORD_VALID_EN adds ports add_word_valid (in, WORDS), rn_word_valid (out, WORDS) and get_word_valid (out, WORDS).
//    - The per-entry mask is stored on add and returned with rn_* / get_*.
//  - Without the macro these ports and the storage are absent; all other behaviour is identical.
// STRUCTURE
//  - Package l1_mshr_pkg: entry-state enum (FREE/PEND/ISSUED) and the entry record typedef.
//    - The record holds addr, data, rw, dirty, cpu_id, victim, plus word mask when SIMD_WORD_VALID_EN is defined.
//  - One sub-module: l1_mshr_prio_enc, the lowest-index-set-bit encoder.
//    - Used for the free-slot search, the pending-entry search and the comp_read select.
// TESTING
//  - Reset, then add addr=0x0000_1040 rw=0 cpu_id=3 -> empty=0.
//    - read_next -> next cycle rn_valid=1, rn_addr=0x1040, rn_mshr_id=0.
//  - Fill all 8 entries -> full=1; a 9th add is dropped.
//    - del tag 5, add again -> entry 5 reused, full=1.
//  - Entry 0 holds 0x1040. comp_addr=0x105C -> same_line_true=1, comp_read=1.
//    - comp_addr=0x0008_1040, victim 0 -> diff_line_true=1.
//    - comp_addr=0x1060 -> comp_true=0.
//  - get tag 2 on FREE entry -> get_valid=0; get tag 0 on PEND entry -> get_valid=1, fields match add.
//  - Same cycle, full MSHR: add + del tag 1 -> add dropped, entry 1 FREE, full=0 next cycle.
//  - enable=0 with add and read_next asserted -> no state change, rn_valid=0.

Source files
------------

// File: rtl/l1_mshr_pkg.sv
// Shared configuration, entry-state encoding and entry record for the L1 MSHR.
// Optional feature macro: SIMD_WORD_VALID_EN adds a per-entry word-valid mask.
package l1_mshr_pkg;

   localparam int unsigned ADDR_BITS   = 32;
   localparam int unsigned DATA_BITS   = 32;
   localparam int unsigned ID_BITS     = 3;
   localparam int unsigned CPU_ID_BITS = 4;
   localparam int unsigned ASSOC_BITS  = 1;
   localparam int unsigned LINE_BITS   = 5;
   localparam int unsigned INDEX_BITS  = 9;
   localparam int unsigned WORDS       = 8;
   localparam int unsigned ENTRIES     = 1 << ID_BITS;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      PEND   = 2'd1,
      ISSUED = 2'd2
   } ent_state_e;

   typedef struct packed {
      logic [ADDR_BITS-1:0]   addr;
      logic [DATA_BITS-1:0]   data;
      logic                   rw;
      logic                   dirty;
      logic [CPU_ID_BITS-1:0] cpu_id;
      logic [ASSOC_BITS-1:0]  victim;
`ifdef SIMD_WORD_VALID_EN
      logic [WORDS-1:0]       word_valid;
`endif
   } mshr_entry_t;

   function automatic logic [ADDR_BITS-LINE_BITS-1:0] line_of(input logic [ADDR_BITS-1:0] a);
      return a[ADDR_BITS-1:LINE_BITS];
   endfunction

   function automatic logic [INDEX_BITS-1:0] set_of(input logic [ADDR_BITS-1:0] a);
      return a[INDEX_BITS+LINE_BITS-1:LINE_BITS];
   endfunction

endpackage

// File: rtl/l1_mshr_if.sv
// Cache-controller <-> MSHR bus: allocate, issue, fetch, free and lookup signals.
// Optional feature macro: SIMD_WORD_VALID_EN adds the word-valid mask signals.
interface l1_mshr_if;
   import l1_mshr_pkg::*;

   logic                   add;
   logic [ADDR_BITS-1:0]   add_addr;
   logic [DATA_BITS-1:0]   add_data;
   logic                   add_rw;
   logic                   add_dirty;
   logic [CPU_ID_BITS-1:0] add_cpu_id;
   logic [ASSOC_BITS-1:0]  add_victim;

   logic                   del;
   logic [ID_BITS-1:0]     del_tag;

   logic                   read_next;
   logic                   rn_valid;
   logic [ADDR_BITS-1:0]   rn_addr;
   logic [DATA_BITS-1:0]   rn_data;
   logic                   rn_rw;
   logic                   rn_dirty;
   logic [CPU_ID_BITS-1:0] rn_cpu_id;
   logic [ASSOC_BITS-1:0]  rn_victim;
   logic [ID_BITS-1:0]     rn_mshr_id;

   logic                   get;
   logic [ID_BITS-1:0]     get_tag;
   logic                   get_valid;
   logic [ADDR_BITS-1:0]   get_addr;
   logic [DATA_BITS-1:0]   get_data;
   logic                   get_rw;
   logic                   get_dirty;
   logic [CPU_ID_BITS-1:0] get_cpu_id;
   logic [ASSOC_BITS-1:0]  get_victim;

   logic [ADDR_BITS-1:0]   comp_addr;
   logic [ASSOC_BITS-1:0]  comp_victim;
   logic                   comp_true;
   logic                   same_line_true;
   logic                   diff_line_true;
   logic                   comp_read;

   logic                   empty;
   logic                   full;

`ifdef SIMD_WORD_VALID_EN
   logic [WORDS-1:0]       add_word_valid;
   logic [WORDS-1:0]       rn_word_valid;
   logic [WORDS-1:0]       get_word_valid;
`endif

   modport master (
      output add, add_addr, add_data, add_rw, add_dirty, add_cpu_id, add_victim,
      output del, del_tag, read_next, get, get_tag, comp_addr, comp_victim,
`ifdef SIMD_WORD_VALID_EN
      output add_word_valid,
      input  rn_word_valid, get_word_valid,
`endif
      input  rn_valid, rn_addr, rn_data, rn_rw, rn_dirty, rn_cpu_id, rn_victim, rn_mshr_id,
      input  get_valid, get_addr, get_data, get_rw, get_dirty, get_cpu_id, get_victim,
      input  comp_true, same_line_true, diff_line_true, comp_read, empty, full
   );

   modport slave (
      input  add, add_addr, add_data, add_rw, add_dirty, add_cpu_id, add_victim,
      input  del, del_tag, read_next, get, get_tag, comp_addr, comp_victim,
`ifdef SIMD_WORD_VALID_EN
      input  add_word_valid,
      output rn_word_valid, get_word_valid,
`endif
      output rn_valid, rn_addr, rn_data, rn_rw, rn_dirty, rn_cpu_id, rn_victim, rn_mshr_id,
      output get_valid, get_addr, get_data, get_rw, get_dirty, get_cpu_id, get_victim,
      output comp_true, same_line_true, diff_line_true, comp_read, empty, full
   );

endinterface

// File: rtl/l1_mshr_prio_enc.sv
// Lowest-index set-bit encoder used for slot, pending-entry and lookup selection.
// Optional feature macro SIMD_WORD_VALID_EN has no effect on this block.
module l1_mshr_prio_enc #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]         req,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   // Scan upward, keeping only the first set bit.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            found = 1'b1;
            idx   = ($clog2(N))'(i);
         end
      end
   end

endmodule

// File: rtl/l1_mshr.sv
// L1 data-cache MSHR file: allocate on miss, issue in index order, fetch on fill, free.
// Optional feature macro: SIMD_WORD_VALID_EN stores and returns a per-entry word mask.
module l1_mshr
   import l1_mshr_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      enable,
   l1_mshr_if.slave  bus
);

   ent_state_e          state_q [ENTRIES];
   ent_state_e          state_d [ENTRIES];
   mshr_entry_t         ent_q   [ENTRIES];
   mshr_entry_t         new_ent;

   logic [ENTRIES-1:0]  in_use;
   logic [ENTRIES-1:0]  pend;
   logic [ENTRIES-1:0]  line_hit;
   logic [ENTRIES-1:0]  diff_hit;

   logic                free_found, pend_found, line_found, diff_found;
   logic [ID_BITS-1:0]  free_idx, pend_idx, line_idx, diff_idx;
   logic                do_add, do_del, do_rn, do_get;

   mshr_entry_t         rn_q, get_q;
   logic                rn_valid_q, get_valid_q;
   logic [ID_BITS-1:0]  rn_id_q;

   // Per-entry occupancy and pending flags derived from the entry states.
   always_comb begin
      in_use = '0;
      pend   = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         in_use[i] = (state_q[i] != FREE);
         pend[i]   = (state_q[i] == PEND);
      end
   end

   l1_mshr_prio_enc #(.N(ENTRIES)) u_free_enc (.req(~in_use), .found(free_found), .idx(free_idx));
   l1_mshr_prio_enc #(.N(ENTRIES)) u_pend_enc (.req(pend),    .found(pend_found), .idx(pend_idx));
   l1_mshr_prio_enc #(.N(ENTRIES)) u_line_enc (.req(line_hit), .found(line_found), .idx(line_idx));
   l1_mshr_prio_enc #(.N(ENTRIES)) u_diff_enc (.req(diff_hit), .found(diff_found), .idx(diff_idx));

   assign bus.empty = ~|in_use;
   assign bus.full  = &in_use;

   // All requests are qualified against pre-edge state; the add slot comes from the
   // pre-edge free set, so it can never be the slot released by a same-cycle del.
   assign do_add = enable & bus.add & free_found;
   assign do_del = enable & bus.del & in_use[bus.del_tag];
   assign do_rn  = enable & bus.read_next & pend_found;
   assign do_get = enable & bus.get & in_use[bus.get_tag];

   // Request fields packed into one record for the allocate write.
   always_comb begin
      new_ent        = '0;
      new_ent.addr   = bus.add_addr;
      new_ent.data   = bus.add_data;
      new_ent.rw     = bus.add_rw;
      new_ent.dirty  = bus.add_dirty;
      new_ent.cpu_id = bus.add_cpu_id;
      new_ent.victim = bus.add_victim;
`ifdef SIMD_WORD_VALID_EN
      new_ent.word_valid = bus.add_word_valid;
`endif
   end

   // Next entry states: issue, then free (a del on the issuing entry wins), then allocate.
   always_comb begin
      for (int unsigned i = 0; i < ENTRIES; i++) state_d[i] = state_q[i];
      if (do_rn)  state_d[pend_idx]    = ISSUED;
      if (do_del) state_d[bus.del_tag] = FREE;
      if (do_add) state_d[free_idx]    = PEND;
   end

   // Entry-state register; reset frees every entry immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) state_q[i] <= FREE;
      end else begin
         for (int unsigned i = 0; i < ENTRIES; i++) state_q[i] <= state_d[i];
      end
   end

   // Entry payload storage; contents are only meaningful while the entry is in use.
   always_ff @(posedge clk) begin
      if (do_add) ent_q[free_idx] <= new_ent;
   end

   // Registered issue and fetch results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rn_valid_q  <= 1'b0;
         rn_id_q     <= '0;
         rn_q        <= '0;
         get_valid_q <= 1'b0;
         get_q       <= '0;
      end else begin
         rn_valid_q  <= do_rn;
         get_valid_q <= do_get;
         if (do_rn) begin
            rn_q    <= ent_q[pend_idx];
            rn_id_q <= pend_idx;
         end
         if (do_get) get_q <= ent_q[bus.get_tag];
      end
   end

   assign bus.rn_valid   = rn_valid_q;
   assign bus.rn_addr    = rn_q.addr;
   assign bus.rn_data    = rn_q.data;
   assign bus.rn_rw      = rn_q.rw;
   assign bus.rn_dirty   = rn_q.dirty;
   assign bus.rn_cpu_id  = rn_q.cpu_id;
   assign bus.rn_victim  = rn_q.victim;
   assign bus.rn_mshr_id = rn_id_q;

   assign bus.get_valid  = get_valid_q;
   assign bus.get_addr   = get_q.addr;
   assign bus.get_data   = get_q.data;
   assign bus.get_rw     = get_q.rw;
   assign bus.get_dirty  = get_q.dirty;
   assign bus.get_cpu_id = get_q.cpu_id;
   assign bus.get_victim = get_q.victim;

`ifdef SIMD_WORD_VALID_EN
   assign bus.rn_word_valid  = rn_q.word_valid;
   assign bus.get_word_valid = get_q.word_valid;
`endif

   // Conflict lookup over in-use entries: same line, or same set/way with a different line.
   always_comb begin
      line_hit = '0;
      diff_hit = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         line_hit[i] = in_use[i] && (line_of(ent_q[i].addr) == line_of(bus.comp_addr));
         diff_hit[i] = in_use[i] && (set_of(ent_q[i].addr) == set_of(bus.comp_addr))
                       && (line_of(ent_q[i].addr) != line_of(bus.comp_addr))
                       && (ent_q[i].victim == bus.comp_victim);
      end
   end

   // Read/write flag of the winning match; same-line matches take priority.
   always_comb begin
      bus.comp_read = 1'b0;
      if (line_found)      bus.comp_read = ~ent_q[line_idx].rw;
      else if (diff_found) bus.comp_read = ~ent_q[diff_idx].rw;
   end

   assign bus.same_line_true = line_found;
   assign bus.diff_line_true = diff_found;
   assign bus.comp_true      = line_found | diff_found;

endmodule

// File: tb/tb_l1_mshr.sv
// Directed self-checking bench for l1_mshr.
// Builds with or without SIMD_WORD_VALID_EN; the mask is held at zero here.
module tb_l1_mshr;
   import l1_mshr_pkg::*;

   logic clk;
   logic reset;
   logic enable;
   int   vectors;
   int   miscompares;

   l1_mshr_if bus ();

   l1_mshr dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.add = 1'b0; bus.add_addr = '0; bus.add_data = '0; bus.add_rw = 1'b0;
      bus.add_dirty = 1'b0; bus.add_cpu_id = '0; bus.add_victim = '0;
      bus.del = 1'b0; bus.del_tag = '0; bus.read_next = 1'b0;
      bus.get = 1'b0; bus.get_tag = '0; bus.comp_addr = '0; bus.comp_victim = '0;
`ifdef SIMD_WORD_VALID_EN
      bus.add_word_valid = '0;
`endif
   endtask

   task automatic set_add(input logic [31:0] a, input logic [31:0] d, input logic rw,
                          input logic [3:0] cid);
      bus.add = 1'b1; bus.add_addr = a; bus.add_data = d; bus.add_rw = rw;
      bus.add_dirty = rw; bus.add_cpu_id = cid; bus.add_victim = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", bus.full); end
      vectors++; if (bus.rn_valid !== 1'b0 || bus.get_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valids got %b%b exp 00", bus.rn_valid, bus.get_valid); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_add();
      set_add(32'h0000_1040, 32'hDEAD_0001, 1'b0, 4'd3);
      tick();
      bus.add = 1'b0;
      vectors++; if (bus.empty !== 1'b0) begin miscompares++; $display("FAIL add_empty got %b exp 0", bus.empty); end
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL add_full got %b exp 0", bus.full); end
   endtask

   task automatic test_get();
      bus.get = 1'b1; bus.get_tag = 3'd2;
      tick();
      vectors++; if (bus.get_valid !== 1'b0) begin miscompares++; $display("FAIL get_free_valid got %b exp 0", bus.get_valid); end
      bus.get_tag = 3'd0;
      tick();
      bus.get = 1'b0;
      vectors++; if (bus.get_valid !== 1'b1) begin miscompares++; $display("FAIL get_pend_valid got %b exp 1", bus.get_valid); end
      vectors++; if (bus.get_addr !== 32'h0000_1040) begin miscompares++; $display("FAIL get_addr got %h exp 00001040", bus.get_addr); end
      vectors++; if (bus.get_data !== 32'hDEAD_0001) begin miscompares++; $display("FAIL get_data got %h exp dead0001", bus.get_data); end
      vectors++; if (bus.get_cpu_id !== 4'd3 || bus.get_rw !== 1'b0) begin miscompares++; $display("FAIL get_fields got cpu %0d rw %b exp cpu 3 rw 0", bus.get_cpu_id, bus.get_rw); end
      tick();
      vectors++; if (bus.get_valid !== 1'b0) begin miscompares++; $display("FAIL get_idle_valid got %b exp 0", bus.get_valid); end
   endtask

   task automatic test_read_next();
      bus.read_next = 1'b1;
      tick();
      bus.read_next = 1'b0;
      vectors++; if (bus.rn_valid !== 1'b1) begin miscompares++; $display("FAIL rn_valid got %b exp 1", bus.rn_valid); end
      vectors++; if (bus.rn_addr !== 32'h0000_1040) begin miscompares++; $display("FAIL rn_addr got %h exp 00001040", bus.rn_addr); end
      vectors++; if (bus.rn_mshr_id !== 3'd0) begin miscompares++; $display("FAIL rn_id got %0d exp 0", bus.rn_mshr_id); end
      tick();
      vectors++; if (bus.rn_valid !== 1'b0) begin miscompares++; $display("FAIL rn_idle_valid got %b exp 0", bus.rn_valid); end
      // nothing pending now: issue request yields no result
      bus.read_next = 1'b1;
      tick();
      bus.read_next = 1'b0;
      vectors++; if (bus.rn_valid !== 1'b0) begin miscompares++; $display("FAIL rn_none_valid got %b exp 0", bus.rn_valid); end
   endtask

   task automatic test_lookup();
      bus.comp_victim = 1'b0;
      bus.comp_addr = 32'h0000_105C; #1;
      vectors++; if ({bus.same_line_true, bus.diff_line_true, bus.comp_true, bus.comp_read} !== 4'b1011) begin miscompares++; $display("FAIL lk_same got %b%b%b%b exp 1011", bus.same_line_true, bus.diff_line_true, bus.comp_true, bus.comp_read); end
      bus.comp_addr = 32'h0008_1040; #1;
      vectors++; if ({bus.same_line_true, bus.diff_line_true, bus.comp_true, bus.comp_read} !== 4'b0111) begin miscompares++; $display("FAIL lk_diff got %b%b%b%b exp 0111", bus.same_line_true, bus.diff_line_true, bus.comp_true, bus.comp_read); end
      bus.comp_victim = 1'b1; #1;
      vectors++; if (bus.comp_true !== 1'b0) begin miscompares++; $display("FAIL lk_diff_way got %b exp 0", bus.comp_true); end
      bus.comp_victim = 1'b0;
      bus.comp_addr = 32'h0000_1060; #1;
      vectors++; if ({bus.comp_true, bus.comp_read} !== 2'b00) begin miscompares++; $display("FAIL lk_none got %b%b exp 00", bus.comp_true, bus.comp_read); end
   endtask

   task automatic test_full();
      for (int i = 1; i < 8; i++) begin
         set_add(32'h2000 + 32'(i) * 32'h100, 32'hA000_0000 + 32'(i), 1'b1, 4'(i));
         tick();
         if (i == 6) begin
            vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL full_at7 got %b exp 0", bus.full); end
         end
      end
      vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL full_at8 got %b exp 1", bus.full); end
      set_add(32'h9999_0000, 32'h0, 1'b0, 4'd15);
      tick();
      bus.add = 1'b0;
      bus.comp_addr = 32'h9999_0000; bus.comp_victim = 1'b1; #1;
      vectors++; if (bus.comp_true !== 1'b0) begin miscompares++; $display("FAIL full_drop got %b exp 0", bus.comp_true); end
      bus.comp_addr = 32'h0000_2310; bus.comp_victim = 1'b0; #1;
      vectors++; if ({bus.same_line_true, bus.comp_read} !== 2'b10) begin miscompares++; $display("FAIL lk_store got %b%b exp 10", bus.same_line_true, bus.comp_read); end
   endtask

   task automatic test_back_to_back();
      bus.read_next = 1'b1;
      tick();
      vectors++; if (bus.rn_valid !== 1'b1 || bus.rn_mshr_id !== 3'd1 || bus.rn_addr !== 32'h2100) begin miscompares++; $display("FAIL b2b_first got v%b id %0d %h exp v1 id 1 00002100", bus.rn_valid, bus.rn_mshr_id, bus.rn_addr); end
      tick();
      bus.read_next = 1'b0;
      vectors++; if (bus.rn_valid !== 1'b1 || bus.rn_mshr_id !== 3'd2 || bus.rn_addr !== 32'h2200) begin miscompares++; $display("FAIL b2b_second got v%b id %0d %h exp v1 id 2 00002200", bus.rn_valid, bus.rn_mshr_id, bus.rn_addr); end
   endtask

   task automatic test_reuse();
      bus.del = 1'b1; bus.del_tag = 3'd5;
      tick();
      bus.del = 1'b0;
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL del5_full got %b exp 0", bus.full); end
      set_add(32'h5555_0020, 32'h1234_5678, 1'b1, 4'd9);
      tick();
      bus.add = 1'b0;
      vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL reuse_full got %b exp 1", bus.full); end
      bus.get = 1'b1; bus.get_tag = 3'd5;
      tick();
      bus.get = 1'b0;
      vectors++; if (bus.get_valid !== 1'b1 || bus.get_addr !== 32'h5555_0020 || bus.get_cpu_id !== 4'd9) begin miscompares++; $display("FAIL reuse_get got v%b %h cpu %0d exp v1 55550020 cpu 9", bus.get_valid, bus.get_addr, bus.get_cpu_id); end
   endtask

   task automatic test_same_cycle();
      set_add(32'h7770_0000, 32'h0, 1'b0, 4'd1);
      bus.del = 1'b1; bus.del_tag = 3'd1;
      tick();
      bus.add = 1'b0; bus.del = 1'b0;
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL sc_full got %b exp 0", bus.full); end
      bus.get = 1'b1; bus.get_tag = 3'd1;
      tick();
      bus.get = 1'b0;
      vectors++; if (bus.get_valid !== 1'b0) begin miscompares++; $display("FAIL sc_entry1 got %b exp 0", bus.get_valid); end
      bus.comp_addr = 32'h7770_0000; bus.comp_victim = 1'b1; #1;
      vectors++; if (bus.comp_true !== 1'b0) begin miscompares++; $display("FAIL sc_add_dropped got %b exp 0", bus.comp_true); end
   endtask

   task automatic test_enable();
      enable = 1'b0;
      set_add(32'h6660_0000, 32'h0, 1'b0, 4'd2);
      bus.read_next = 1'b1;
      bus.get = 1'b1; bus.get_tag = 3'd0;
      tick();
      idle_inputs();
      vectors++; if ({bus.rn_valid, bus.get_valid} !== 2'b00) begin miscompares++; $display("FAIL en_valids got %b%b exp 00", bus.rn_valid, bus.get_valid); end
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL en_full got %b exp 0", bus.full); end
      enable = 1'b1;
      bus.comp_addr = 32'h6660_0000; bus.comp_victim = 1'b1; #1;
      vectors++; if (bus.comp_true !== 1'b0) begin miscompares++; $display("FAIL en_add_ignored got %b exp 0", bus.comp_true); end
      bus.read_next = 1'b1;
      tick();
      bus.read_next = 1'b0;
      vectors++; if (bus.rn_valid !== 1'b1 || bus.rn_mshr_id !== 3'd3 || bus.rn_addr !== 32'h2300) begin miscompares++; $display("FAIL en_rn_kept got v%b id %0d %h exp v1 id 3 00002300", bus.rn_valid, bus.rn_mshr_id, bus.rn_addr); end
   endtask

   task automatic test_reset_mid();
      bus.read_next = 1'b1;
      tick();
      bus.read_next = 1'b0;
      #2 reset = 1'b0;
      #1;
      vectors++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin miscompares++; $display("FAIL mid_reset_state got e%b f%b exp e1 f0", bus.empty, bus.full); end
      vectors++; if (bus.rn_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_rn got %b exp 0", bus.rn_valid); end
      tick();
      reset = 1'b1;
      tick();
      vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL post_reset_empty got %b exp 1", bus.empty); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_add();
      test_get();
      test_read_next();
      test_lookup();
      test_full();
      test_back_to_back();
      test_reuse();
      test_same_cycle();
      test_enable();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
